tdm_rx: RTL and testbench

TDM serial receiver: deserializes the `tdm_in` stream into per-slot parallel samples, using the `bclk`/`wclk` pair that `top` drives. It is the receive-side counterpart of the `tdm_gen` stimulus transmitter. It sits between the TDM pins and the audio datapath inside `top`. All logic runs on `mclk`; `bclk`, `wclk` and `tdm_in` are synchronized and edge-detected, never used as clocks.

---
 rtl/tdm_pkg.sv | 13 +
 rtl/tdm_edge_sync.sv | 46 ++++
 rtl/tdm_rx.sv | 133 +++++++++++++
 tb/tb_tdm_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Constants and the receiver state type shared by the TDM transmit and receive sides.
package tdm_pkg;

    localparam int TDM_SLOTS     = 8;
    localparam int TDM_SLOT_BITS = 32;
    localparam int TDM_DATA_BITS = 24;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_edge_sync.sv
// Brings bclk/wclk/tdm_in into the mclk domain and flags each bclk rising edge.
// wclk and tdm_in get one extra stage so they line up with the registered bit_en pulse.
module tdm_edge_sync
    import tdm_pkg::*;
(
    input  logic mclk,
    input  logic rst_n,
    input  logic bclk,
    input  logic wclk,
    input  logic tdm_in,
    output logic bit_en,
    output logic wclk_sync,
    output logic data_sync
);

    logic bclk_meta, bclk_s, bclk_hist;
    logic wclk_meta, wclk_s;
    logic data_meta, data_s;

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            bclk_meta <= 1'b0;
            bclk_s    <= 1'b0;
            bclk_hist <= 1'b0;
            bit_en    <= 1'b0;
            wclk_meta <= 1'b0;
            wclk_s    <= 1'b0;
            wclk_sync <= 1'b0;
            data_meta <= 1'b0;
            data_s    <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            bclk_meta <= bclk;
            bclk_s    <= bclk_meta;
            bclk_hist <= bclk_s;
            bit_en    <= bclk_s & ~bclk_hist;
            wclk_meta <= wclk;
            wclk_s    <= wclk_meta;
            wclk_sync <= wclk_s;
            data_meta <= tdm_in;
            data_s    <= data_meta;
            data_sync <= data_s;
        end
    end

endmodule

// File: rtl/tdm_rx.sv
// TDM serial receiver: per-slot MSB-first capture with frame-sync lock tracking.
// TDM_RX_FRAME_CHECK_EN enables frame-length checking and the sync_err pulse.
module tdm_rx
    import tdm_pkg::*;
#(
    parameter int SLOTS     = TDM_SLOTS,
    parameter int SLOT_BITS = TDM_SLOT_BITS,
    parameter int DATA_BITS = TDM_DATA_BITS
) (
    input  logic                     mclk,
    input  logic                     rst_n,
    input  logic                     bclk,
    input  logic                     wclk,
    input  logic                     tdm_in,
    output logic [DATA_BITS-1:0]     sample_data,
    output logic [$clog2(SLOTS)-1:0] sample_slot,
    output logic                     sample_valid,
    output logic                     frame_start,
    output logic                     locked,
    output logic                     sync_err
);

    localparam int BW  = $clog2(SLOT_BITS);
    localparam int SW  = $clog2(SLOTS);
    localparam int SHW = DATA_BITS - 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
    localparam logic [BW-1:0] BIT_DLAST = BW'(DATA_BITS - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);

    logic            bit_en, wclk_sync, data_sync, wclk_prev;
    logic            sync_ev, frame_end, in_word, word_done, drop_word;
    tdm_state_e      state;
    logic [BW-1:0]   bit_cnt;
    logic [SW-1:0]   slot_cnt;
    logic [SHW-1:0]  shift;

    tdm_edge_sync u_sync (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .bclk      (bclk),
        .wclk      (wclk),
        .tdm_in    (tdm_in),
        .bit_en    (bit_en),
        .wclk_sync (wclk_sync),
        .data_sync (data_sync)
    );

    // Counters hold the position of the bit arriving at this bit_en.
    assign sync_ev   = bit_en & wclk_sync & ~wclk_prev;
    assign frame_end = (slot_cnt == SLOT_LAST) && (bit_cnt == BIT_LAST);
    assign in_word   = (bit_cnt <= BIT_DLAST);
    assign word_done = (bit_cnt == BIT_DLAST);

`ifdef TDM_RX_FRAME_CHECK_EN
    assign drop_word = sync_ev & ~frame_end;
`else
    assign drop_word = 1'b0;
    assign sync_err  = 1'b0;
`endif

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state        <= ST_HUNT;
            locked       <= 1'b0;
            bit_cnt      <= '0;
            slot_cnt     <= '0;
            shift        <= '0;
            wclk_prev    <= 1'b0;
            sample_data  <= '0;
            sample_slot  <= '0;
            sample_valid <= 1'b0;
            frame_start  <= 1'b0;
`ifdef TDM_RX_FRAME_CHECK_EN
            sync_err     <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
            frame_start  <= 1'b0;
`ifdef TDM_RX_FRAME_CHECK_EN
            sync_err     <= 1'b0;
`endif
            if (bit_en) begin
                wclk_prev <= wclk_sync;
                case (state)
                    ST_HUNT: begin
                        if (sync_ev) begin
                            state       <= ST_RUN;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                            bit_cnt     <= '0;
                            slot_cnt    <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (in_word) begin
                            shift <= SHW'({shift, data_sync});
                        end
                        // A word completing on the frame's last bit still goes out ahead of the resync.
                        if (word_done && !drop_word) begin
                            sample_data  <= {shift, data_sync};
                            sample_slot  <= slot_cnt;
                            sample_valid <= 1'b1;
                        end
                        if (sync_ev) begin
                            bit_cnt  <= '0;
                            slot_cnt <= '0;
`ifdef TDM_RX_FRAME_CHECK_EN
                            if (frame_end) frame_start <= 1'b1;
                            else           sync_err    <= 1'b1;
`else
                            frame_start <= 1'b1;
`endif
                        end else if (bit_cnt == BIT_LAST) begin
                            bit_cnt  <= '0;
                            slot_cnt <= frame_end ? '0 : slot_cnt + 1'b1;
`ifdef TDM_RX_FRAME_CHECK_EN
                            if (frame_end) begin
                                sync_err <= 1'b1;
                                state    <= ST_HUNT;
                                locked   <= 1'b0;
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_rx.sv
// Self-checking bench for tdm_rx: randomized TDM frames against a bit-position reference model.
module tb_tdm_rx;
    import tdm_pkg::*;

    localparam int SLOTS = TDM_SLOTS;
    localparam int SB    = TDM_SLOT_BITS;
    localparam int DB    = TDM_DATA_BITS;
    localparam int FRAME = SLOTS * SB;
`ifdef TDM_RX_FRAME_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  slot;
        logic [31:0] data;
    } ev_t;
    localparam logic [1:0] EV_SAMPLE = 2'd0, EV_FS = 2'd1, EV_ERR = 2'd2;

    logic mclk = 1'b0, rst_n = 1'b0, bclk = 1'b0, wclk = 1'b0, tdm_in = 1'b0;
    logic [DB-1:0]            sample_data;
    logic [$clog2(SLOTS)-1:0] sample_slot;
    logic                     sample_valid, frame_start, locked, sync_err;

    int   total = 0, bad = 0, cyc = 0;
    ev_t  exp_q[$], got_q[$];
    int   sv_cyc[$], rise_log[$];
    bit   sw[$], sd[$];
    bit   m_run, m_prev, m_hist[$];
    int   m_pos;

    tdm_rx dut (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .bclk         (bclk),
        .wclk         (wclk),
        .tdm_in       (tdm_in),
        .sample_data  (sample_data),
        .sample_slot  (sample_slot),
        .sample_valid (sample_valid),
        .frame_start  (frame_start),
        .locked       (locked),
        .sync_err     (sync_err)
    );

    always #40 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    always @(negedge mclk) begin
        ev_t e;
        if (sample_valid) begin
            e.kind = EV_SAMPLE; e.slot = 8'(sample_slot); e.data = 32'(sample_data);
            got_q.push_back(e);
            sv_cyc.push_back(cyc);
        end
        if (frame_start) begin
            e.kind = EV_FS; e.slot = '0; e.data = '0;
            got_q.push_back(e);
        end
        if (sync_err) begin
            e.kind = EV_ERR; e.slot = '0; e.data = '0;
            got_q.push_back(e);
        end
    end

    // Reference: position since the last accepted sync; a word is the last DB bits received.
    task automatic model_bit(input bit w, input bit d);
        ev_t e;
        int b, slot;
        bit sync, early;
        logic [31:0] word;
        sync = w && !m_prev;
        m_prev = w;
        m_hist.push_back(d);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        e.slot = '0; e.data = '0;
        if (!m_run) begin
            if (sync) begin
                m_run = 1'b1; m_pos = 0;
                e.kind = EV_FS; exp_q.push_back(e);
            end
            return;
        end
        b     = m_pos % SB;
        slot  = (m_pos / SB) % SLOTS;
        early = CHECK && sync && ((m_pos % FRAME) != FRAME - 1);
        if (b == DB - 1 && !early) begin
            word = '0;
            foreach (m_hist[k]) word = {word[30:0], m_hist[k]};
            e.kind = EV_SAMPLE; e.slot = 8'(slot); e.data = word;
            exp_q.push_back(e);
            e.slot = '0; e.data = '0;
        end
        if (sync) begin
            m_pos = 0;
            e.kind = early ? EV_ERR : EV_FS;
            exp_q.push_back(e);
        end else begin
            m_pos++;
            if (CHECK && m_pos == FRAME) begin
                e.kind = EV_ERR; exp_q.push_back(e);
                m_run = 1'b0;
            end
        end
    endtask

    function automatic logic [DB-1:0] fixed_word(input int s);
        if (s == 0) return DB'(24'h800001);
        if (s == SLOTS - 1) return DB'(24'h7FFFFF);
        return DB'(s * 32'h00111111 ^ 32'h00A5A5A5);
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            sw.push_back(1'b0);
            sd.push_back(1'($urandom));
        end
    endtask

    // wclk is raised on the bit before bit 0 (one-bit data delay).
    task automatic add_frame(input bit sync, input bit fixed, input bit pad_ones, input int nbits);
        logic [DB-1:0] word;
        word = '0;
        if (sync) begin
            if (sw.size() == 0) begin
                sw.push_back(1'b1);
                sd.push_back(1'($urandom));
            end else begin
                sw[sw.size()-1] = 1'b1;
            end
        end
        for (int i = 0; i < nbits; i++) begin
            int s, b;
            s = i / SB;
            b = i % SB;
            if (b == 0) word = fixed ? fixed_word(s) : DB'($urandom);
            sw.push_back(1'b0);
            sd.push_back(b < DB ? word[DB-1-b] : (pad_ones ? 1'b1 : 1'($urandom)));
        end
    endtask

    task automatic end_with_sync();
        sw[sw.size()-1] = 1'b1;
    endtask

    task automatic drive_bits();
        for (int i = 0; i < sw.size(); i++) begin
            @(negedge mclk);
            bclk = 1'b0; wclk = sw[i]; tdm_in = sd[i];
            @(negedge mclk);
            @(negedge mclk);
            bclk = 1'b1;
            rise_log.push_back(cyc);
            @(negedge mclk);
            model_bit(sw[i], sd[i]);
        end
        @(negedge mclk);
        bclk = 1'b0;
        sw.delete();
        sd.delete();
        repeat (8) @(negedge mclk);
    endtask

    task automatic do_reset();
        @(negedge mclk);
        rst_n = 1'b0; bclk = 1'b0; wclk = 1'b0; tdm_in = 1'b0;
        repeat (4) @(negedge mclk);
        rst_n = 1'b1;
        m_run = 1'b0; m_prev = 1'b0; m_pos = 0;
        got_q.delete(); exp_q.delete(); sv_cyc.delete(); rise_log.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge mclk);
        total++; if (sample_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", sample_data); end
        total++; if (sample_slot !== '0) begin bad++; $display("FAIL rst_slot got=%h exp=0", sample_slot); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sample_valid); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", sync_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_slot_data();
        do_reset();
        add_idle(2);
        add_frame(1'b1, 1'b1, 1'b1, FRAME);
        add_frame(1'b1, 1'b1, 1'b1, FRAME);
        end_with_sync();
        drive_bits();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL slots_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL slots_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL slots_locked got=%b exp=1", locked); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        add_idle(2);
        for (int f = 0; f < 4; f++) add_frame(1'b1, 1'b0, 1'b0, FRAME);
        end_with_sync();
        drive_bits();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL b2b_locked got=%b exp=1", locked); end
    endtask

    task automatic test_early_sync();
        int n_err;
        do_reset();
        add_idle(2);
        add_frame(1'b1, 1'b0, 1'b0, FRAME);
        add_frame(1'b1, 1'b0, 1'b0, 3 * SB + 6);
        add_frame(1'b1, 1'b0, 1'b0, FRAME);
        end_with_sync();
        drive_bits();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL early_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL early_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        n_err = 0;
        foreach (got_q[i]) if (got_q[i].kind == EV_ERR) n_err++;
        total++; if (n_err != int'(CHECK)) begin bad++; $display("FAIL early_errs got=%0d exp=%0d", n_err, int'(CHECK)); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL early_locked got=%b exp=1", locked); end
    endtask

    task automatic test_missing_sync();
        do_reset();
        add_idle(2);
        add_frame(1'b1, 1'b0, 1'b0, FRAME);
        add_frame(1'b0, 1'b0, 1'b0, FRAME);
        drive_bits();
        total++; if (locked !== !CHECK) begin bad++; $display("FAIL miss_locked got=%b exp=%b", locked, !CHECK); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL miss_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL miss_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
        add_frame(1'b1, 1'b0, 1'b0, FRAME);
        end_with_sync();
        drive_bits();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL relock_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL relock_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock_locked got=%b exp=1", locked); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        add_idle(2);
        add_frame(1'b1, 1'b0, 1'b0, FRAME);
        add_frame(1'b1, 1'b0, 1'b0, 5 * SB + 29);
        drive_bits();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_pre_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_pre_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        rst_n = 1'b0;
        @(negedge mclk);
        total++; if (sample_data !== '0) begin bad++; $display("FAIL mid_data got=%h exp=0", sample_data); end
        total++; if (sample_slot !== '0) begin bad++; $display("FAIL mid_slot got=%h exp=0", sample_slot); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked got=%b exp=0", locked); end
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        m_run = 1'b0; m_prev = 1'b0; m_pos = 0;
        got_q.delete(); exp_q.delete();
        add_frame(1'b0, 1'b0, 1'b0, FRAME - (5 * SB + 29));
        add_frame(1'b0, 1'b0, 1'b0, FRAME);
        add_frame(1'b1, 1'b0, 1'b0, FRAME);
        end_with_sync();
        drive_bits();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_post_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_post_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_latency();
        do_reset();
        add_idle(2);
        add_frame(1'b1, 1'b0, 1'b0, FRAME);
        end_with_sync();
        drive_bits();
        total++;
        if (sv_cyc.size() == 0) begin
            bad++; $display("FAIL latency got=no_sample exp=%0d", rise_log[2 + DB - 1] + 4);
        end else if (sv_cyc[0] != rise_log[2 + DB - 1] + 4) begin
            bad++; $display("FAIL latency got=%0d exp=%0d", sv_cyc[0], rise_log[2 + DB - 1] + 4);
        end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL lat_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL lat_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_slot_data();
        test_back_to_back();
        test_early_sync();
        test_missing_sync();
        test_mid_reset();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
